// File: rtl/opnd_mux_rr.sv
// Operand mux: N input channels funnelled into one registered output,
// chosen by round-robin (mode 0) or a fixed select (mode 1).
module opnd_mux_rr #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_chan,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [N-1:0][W-1:0] din;
    logic [W-1:0]        data_q, data_d;
    logic [SW-1:0]       chan_q, chan_d;
    logic                vld_q, vld_d;
    logic [SW-1:0]       ptr_q, ptr_d;

    logic                accept;
    logic                gnt_vld;
    logic [SW-1:0]       gnt;
    logic                xfer;

    assign din    = in_data;
    assign accept = ~vld_q | out_ready;

    // Grant never looks at out_ready; accept only gates in_ready.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_vld = 1'b0;
        if (!mode) begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) idx = idx - N;
                if (!gnt_vld && in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = SW'(idx);
                end
            end
        end else if (int'(sel) < N) begin
            if (in_valid[sel]) begin
                gnt_vld = 1'b1;
                gnt     = sel;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && gnt_vld) in_ready[gnt] = accept;
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        data_d = data_q;
        chan_d = chan_q;
        vld_d  = vld_q;
        ptr_d  = ptr_q;
        if (xfer) begin
            data_d = din[gnt];
            chan_d = gnt;
            vld_d  = 1'b1;
            if (!mode) ptr_d = (gnt == SW'(N - 1)) ? '0 : gnt + 1'b1;
        end else if (accept) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            chan_q <= '0;
            vld_q  <= 1'b0;
            ptr_q  <= '0;
        end else begin
            data_q <= data_d;
            chan_q <= chan_d;
            vld_q  <= vld_d;
            ptr_q  <= ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = vld_q;

endmodule

// File: doc/opnd_mux_rr.md
OPND_MUX_RR -- requirements
Module: opnd_mux_rr

Interface
REQ-001 SHALL have parameter W, default 16: data width per channel.
REQ-002 SHALL have parameter N, default 4: input channel count (2..16).
REQ-003 SHALL have parameter SW, default $clog2(N): select/channel-index width.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port in_data  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
REQ-008 SHALL have port in_valid  input  N  per-channel valid.
REQ-009 SHALL have port in_ready  output  N  per-channel ready (combinational).
REQ-010 SHALL have port mode  input  1  0 = round-robin, 1 = fixed select.
REQ-011 SHALL have port sel  input  SW  channel index used when mode = 1.
REQ-012 SHALL have port out_data  output  W  registered selected data.
REQ-013 SHALL have port out_chan  output  SW  registered index of the source channel of out_data.
REQ-014 SHALL have port out_valid  output  1  registered output valid.
REQ-015 SHALL have port out_ready  input  1  downstream ready.

Function
REQ-016 SHALL define accept = ~out_valid | out_ready, i.e. the output register may load this cycle.
REQ-017 SHALL, in mode 0, grant the first channel with in_valid = 1, searching upward from pointer ptr with wrap N-1 -> 0.
REQ-018 SHALL, in mode 1, grant channel sel only if in_valid[sel] = 1; sel >= N grants nothing.
REQ-019 SHALL assert in_ready[g] = accept for the granted channel g only; all other in_ready bits are 0; no grant drives in_ready = 0.
REQ-020 SHALL treat a transfer as in_valid[g] & in_ready[g]; on a transfer, out_data <= channel g data, out_chan <= g, out_valid <= 1 at the next edge (latency 1 cycle).
REQ-021 SHALL, when accept = 1 and no transfer occurs, clear out_valid at the next edge.
REQ-022 SHALL, when out_valid = 1 and out_ready = 0, hold out_data, out_chan and out_valid unchanged; no input is accepted.
REQ-023 SHALL sustain one transfer per cycle when out_ready is held at 1.
REQ-024 SHALL update ptr <= (g+1) mod N only on a mode-0 transfer; ptr is unchanged on no grant, on stall, and in mode 1.
REQ-025 SHALL apply a change of mode or sel to the grant in the same cycle; a word already in the output register is not affected.
REQ-026 SHALL make grant depend only on in_valid, mode, sel and ptr, never on out_ready (accept gates only in_ready), so in_valid is never required to wait on in_ready.
REQ-027 SHALL copy data bit-exactly (no width change); for each bit, selection is equivalent to a chain of 2:1 muxes o = (i0 & ~s) | (i1 & s).

Reset
REQ-028 SHALL, with rst = 1 at a clock edge, set out_valid = 0, out_data = 0, out_chan = 0 and ptr = 0.
REQ-029 SHALL drive all in_ready bits to 0 while rst = 1.
REQ-030 SHALL discard a word held in the output register when reset is asserted mid-stall; it is never presented after reset.
REQ-031 SHALL accept the first transfer on the first edge after rst deasserts.

Verification
REQ-032 SHALL cover this scenario: N=4, mode 0, all in_valid = 1111, out_ready = 1, data[i] = 16'h00A0+i -> out_chan sequence 0,1,2,3,0, one word per cycle, first out_valid 1 cycle after reset release.
REQ-033 SHALL cover this scenario: mode 0, in_valid = 0100 then 0001 with ptr = 3 -> grants 2 then 0; ptr ends at 1.
REQ-034 SHALL cover this scenario: out_valid = 1, out_ready = 0 for 3 cycles with all valids high -> out_data/out_chan frozen, in_ready = 0000, ptr frozen; the next word follows on the first cycle out_ready = 1.
REQ-035 SHALL cover this scenario: mode 1, sel = 2, in_valid = 1111, data[2] = 16'h1234 -> out_data = 16'h1234 and out_chan = 2 every cycle, ptr unchanged; sel = 2 with in_valid[2] = 0 -> out_valid = 0 after 1 cycle.
REQ-036 SHALL cover this scenario: rst asserted while out_valid = 1, out_ready = 0 -> after the edge out_valid = 0, out_data = 0, ptr = 0; in_ready = 0000 while rst = 1.
REQ-037 SHALL cover this scenario: in_valid = 0000, out_ready = 1 -> out_valid = 0 and ptr unchanged for all cycles.
